dma_priority_arbiter: RTL
=========================

Name: dma_priority_arbiter

Overview:
Channel request resolver and bus-hold sequencer for the 4-channel DMA controller. It collects hardware DREQ and software requests, qualifies them with mask and sense bits, and raises HRQ to the CPU. On HLDA it picks one channel by fixed or rotating priority and holds that grant for timing-and-control until the service completes. It drives DACK and the granted channel index consumed by the datapath address/word-count logic.

Parameters:
NUM_CH, 4, number of DMA channels (implementation only needs to support 4; CH_W = $clog2(NUM_CH))
RELEASE_CYCLES, 1, cycles HRQ is held low after a grant ends before a new request is raised

Ports:
CLK  input  1  system clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
DREQ  input  NUM_CH  hardware data requests, polarity per dreqSenseLow
HLDA  input  1  hold acknowledge from CPU
maskReg  input  NUM_CH  1 = channel masked (hardware DREQ ignored)
requestReg  input  NUM_CH  software requests, active-high, not maskable
priorityType  input  1  0 = fixed (ch0 highest), 1 = rotating
dreqSenseLow  input  1  1 = DREQ active-low
controllerDisable  input  1  1 = no new HRQ raised
assertDACK  input  1  timing-and-control window in which DACK is driven
serviceDone  input  1  one-cycle pulse: current channel service finished (TC/EOP/single transfer)
HRQ  output  1  hold request to CPU
DACK  output  NUM_CH  one-hot acknowledge, active-high
grantValid  output  1  a channel is granted
grantChannel  output  CH_W  index of granted channel
abortPulse  output  1  one-cycle pulse when HLDA is lost during a grant

Behaviour:
- pending[i] = ((DREQ[i] ^ dreqSenseLow) & ~maskReg[i]) | requestReg[i]. Registered each cycle, so 1-cycle sampling latency.
- Reset (RESET_N=0, asynchronous): state=IDLE, HRQ=0, DACK=0000, grantValid=0, grantChannel=0, abortPulse=0, rotation pointer topPtr=0, release counter=0.
- States:
  - IDLE: HRQ=0. Goes to HOLD_REQ if |pending and !controllerDisable.
  - HOLD_REQ: HRQ=1. If HLDA=1, resolve the winner from pending in the same cycle, latch it into grantChannel, and go to GRANT. If pending goes all-zero before HLDA, go to IDLE (HRQ drops next cycle).
  - GRANT: HRQ=1, grantValid=1, grantChannel stable for the whole grant. DACK = onehot(grantChannel) when assertDACK, else 0000; DACK is registered, so it follows assertDACK by 1 cycle. On serviceDone, go to RELEASE. If priorityType=1, set topPtr = (grantChannel+1) mod NUM_CH.
  - RELEASE: HRQ=0, grantValid=0, DACK=0000 for RELEASE_CYCLES cycles, then IDLE.
- Fixed priority: lowest index wins. Rotating priority: search from topPtr upward, wrapping mod NUM_CH. topPtr changes only on serviceDone, never while priorityType=0.
- Simultaneous serviceDone and HLDA drop in GRANT: treat as a normal completion. Rotate, go to RELEASE, abortPulse=0.
- HLDA=0 in GRANT without serviceDone: abortPulse=1 for one cycle. DACK=0000 and grantValid=0 next cycle, no rotation, go to IDLE.
- controllerDisable asserted in HOLD_REQ or GRANT does not cancel the current sequence. It only blocks leaving IDLE.
- A channel's request deasserting during GRANT does not release the grant; only serviceDone or HLDA loss does.
- Requests arriving while in RELEASE are honoured after the release window, never earlier.
- DACK is always one-hot or zero.

Decomposition:
- Shared dma package: arbiter state enum (IDLE, HOLD_REQ, GRANT, RELEASE, one-hot encoded), NUM_CH/CH_W constants, priority-type constants.
- One natural sub-module: dma_priority_resolver. It is combinational, takes pending, topPtr and priorityType, and outputs winner index and a valid flag. It is reused by the checker to compute expected grants.

Test Plan:
- Fixed priority: priorityType=0, DREQ=0011 held, HLDA tied to 1 → HRQ=1 two cycles after DREQ; grantChannel=0; DACK=0001 one cycle after assertDACK.
- Rotating priority: priorityType=1, DREQ=1111 held, serviceDone after each grant → grant order 0,1,2,3,0 with one RELEASE cycle (HRQ=0) between grants.
- Mask and software request: maskReg=0001, DREQ=0001, requestReg=0000 → HRQ stays 0. Then requestReg=0001 → grantChannel=0.
- Sense inversion: dreqSenseLow=1, DREQ=1011 → only ch2 pending; grantChannel=2, DACK=0100.
- HLDA loss: in GRANT on ch1 with priorityType=1, drop HLDA → abortPulse=1 for one cycle, DACK=0000, topPtr unchanged; the next grant with DREQ=0011 picks ch0.
- Asynchronous reset mid-GRANT: RESET_N low between clock edges → HRQ=0, DACK=0000, grantValid=0 immediately; topPtr=0 after release.

Source files
------------

// File: rtl/dma_priority_arbiter_pkg.sv
// ============================================================================
//  Module   : dma_priority_arbiter_pkg
//  Purpose  : Shared types and constants for the DMA channel arbiter:
//             one-hot arbiter state encoding, default channel count and
//             priority-type encodings.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_priority_arbiter_pkg;

   localparam int NUM_CH_DEFAULT = 4;
   localparam int CH_W_DEFAULT   = $clog2(NUM_CH_DEFAULT);

   localparam logic PRIO_FIXED  = 1'b0;   // ch0 always highest
   localparam logic PRIO_ROTATE = 1'b1;   // search starts at rotation pointer

   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0001,
      ST_HOLD_REQ = 4'b0010,
      ST_GRANT    = 4'b0100,
      ST_RELEASE  = 4'b1000
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/dma_priority_resolver.sv
// ============================================================================
//  Module   : dma_priority_resolver
//  Purpose  : Combinational winner selection among pending DMA channels.
//             Fixed mode: lowest index wins. Rotating mode: search starts at
//             top_ptr and wraps modulo NUM_CH.
//  Ports    : pending       - qualified request vector
//             top_ptr       - rotation start index
//             priority_type - PRIO_FIXED / PRIO_ROTATE
//             winner        - index of selected channel (0 when none)
//             valid         - at least one channel pending
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_resolver
   import dma_priority_arbiter_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEFAULT
) (
   input  logic [NUM_CH-1:0]         pending,
   input  logic [$clog2(NUM_CH)-1:0] top_ptr,
   input  logic                      priority_type,
   output logic [$clog2(NUM_CH)-1:0] winner,
   output logic                      valid
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [CH_W-1:0] base;
   int              idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      base   = (priority_type == PRIO_ROTATE) ? top_ptr : '0;
      // Walk the channels in search order; the first pending one wins.
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(base) + i) % NUM_CH;
         if (!valid && pending[idx[CH_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[CH_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
// ============================================================================
//  Module   : dma_priority_arbiter
//  Purpose  : DMA request resolver and bus-hold sequencer. Qualifies DREQ /
//             software requests, raises HRQ, picks a channel on HLDA and
//             holds the grant until serviceDone or HLDA loss.
//  Ports    : CLK, RESET_N (async, active-low)
//             DREQ, maskReg, requestReg, dreqSenseLow - request qualification
//             HLDA, controllerDisable, priorityType    - sequencing control
//             assertDACK, serviceDone                  - timing-and-control
//             HRQ, DACK, grantValid, grantChannel, abortPulse - outputs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_arbiter
   import dma_priority_arbiter_pkg::*;
#(
   parameter int NUM_CH         = NUM_CH_DEFAULT,
   parameter int RELEASE_CYCLES = 1
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [NUM_CH-1:0]         DREQ,
   input  logic                      HLDA,
   input  logic [NUM_CH-1:0]         maskReg,
   input  logic [NUM_CH-1:0]         requestReg,
   input  logic                      priorityType,
   input  logic                      dreqSenseLow,
   input  logic                      controllerDisable,
   input  logic                      assertDACK,
   input  logic                      serviceDone,
   output logic                      HRQ,
   output logic [NUM_CH-1:0]         DACK,
   output logic                      grantValid,
   output logic [$clog2(NUM_CH)-1:0] grantChannel,
   output logic                      abortPulse
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

   arb_state_e        state, state_nxt;
   logic [NUM_CH-1:0] pending_raw, pending_q;
   logic [CH_W-1:0]   top_ptr, grant_ch, win_ch;
   logic              win_valid;
   logic [RC_W-1:0]   rel_cnt;
   logic [NUM_CH-1:0] dack_q;
   logic              abort_q;
   logic              svc_end, abort_evt, any_pending;

   // Hardware requests are sense-corrected and maskable; software requests
   // bypass the mask.
   assign pending_raw = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | requestReg;
   assign any_pending = |pending_q;

   dma_priority_resolver #(.NUM_CH(NUM_CH)) u_resolver (
      .pending       (pending_q),
      .top_ptr       (top_ptr),
      .priority_type (priorityType),
      .winner        (win_ch),
      .valid         (win_valid)
   );

   // Completion wins over a simultaneous HLDA drop.
   assign svc_end   = (state == ST_GRANT) && serviceDone;
   assign abort_evt = (state == ST_GRANT) && !HLDA && !serviceDone;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (any_pending && !controllerDisable) state_nxt = ST_HOLD_REQ;
         end
         ST_HOLD_REQ: begin
            if (!win_valid)  state_nxt = ST_IDLE;
            else if (HLDA)   state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (serviceDone) state_nxt = ST_RELEASE;
            else if (!HLDA)  state_nxt = ST_IDLE;
         end
         ST_RELEASE: begin
            if (rel_cnt == RC_W'(RELEASE_CYCLES - 1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= ST_IDLE;
         pending_q <= '0;
         top_ptr   <= '0;
         grant_ch  <= '0;
         rel_cnt   <= '0;
         dack_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending_q <= pending_raw;
         abort_q   <= abort_evt;

         if (state == ST_HOLD_REQ && state_nxt == ST_GRANT)
            grant_ch <= win_ch;

         if (svc_end && priorityType == PRIO_ROTATE)
            top_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;

         // DACK only while the grant persists into the next cycle, so it
         // clears together with grantValid on completion or abort.
         if (state == ST_GRANT && state_nxt == ST_GRANT && assertDACK)
            dack_q <= {{(NUM_CH-1){1'b0}}, 1'b1} << grant_ch;
         else
            dack_q <= '0;

         if (state == ST_RELEASE && state_nxt == ST_RELEASE)
            rel_cnt <= rel_cnt + 1'b1;
         else
            rel_cnt <= '0;
      end
   end

   assign HRQ          = (state == ST_HOLD_REQ) || (state == ST_GRANT);
   assign grantValid   = (state == ST_GRANT);
   assign grantChannel = grant_ch;
   assign DACK         = dack_q;
   assign abortPulse   = abort_q;

endmodule

`default_nettype wire
